// File: rtl/melody_sequencer.sv
// Melody sequencer: walks a song stored in an external synchronous note ROM,
// one note code per step at a fixed step period. It supports start/stop/pause,
// song select, loop or one-shot playback, an end-of-song marker, and
// step/done strobes. All outputs come straight from registers.
module melody_sequencer #(
    parameter int CLK_DIV   = 6000000,
    parameter int NOTE_W    = 5,
    parameter int STEP_W    = 7,
    parameter int SONG_W    = 2,
    parameter int REST_CODE = 25,
    parameter int END_CODE  = 31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     pause,
    input  logic [SONG_W-1:0]        song_sel,
    input  logic                     loop_en,
    output logic [SONG_W+STEP_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0]        rom_data,
    output logic [NOTE_W-1:0]        note,
    output logic                     note_on,
    output logic                     note_strobe,
    output logic [STEP_W-1:0]        step,
    output logic                     busy,
    output logic                     done
);

    localparam int                 TICK_W    = $clog2(CLK_DIV);
    localparam logic [TICK_W-1:0]  TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(CLK_DIV - 2);
    localparam logic [STEP_W-1:0]  STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
    localparam logic [STEP_W-1:0]  STEP_MAX  = {STEP_W{1'b1}};
    localparam logic [NOTE_W-1:0]  REST_N    = NOTE_W'(REST_CODE);
    localparam logic [NOTE_W-1:0]  END_N     = NOTE_W'(END_CODE);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    state_e                     state_r, state_s;
    logic [SONG_W-1:0]          song_r, song_s;
    logic                       loop_r, loop_s;
    logic [STEP_W-1:0]          step_r, step_s;
    logic                       wrap_r, wrap_s;   // last step advanced past STEP_MAX
    logic [TICK_W-1:0]          tick_r, tick_s;
    logic [NOTE_W-1:0]          note_r, note_s;
    logic                       note_on_r, note_on_s;
    logic                       strobe_r, strobe_s;
    logic                       done_r, done_s;
    logic                       busy_r, busy_s;
    logic [SONG_W+STEP_W-1:0]   addr_r, addr_s;

    // Next-state and next-output logic; priority is stop > start > progress.
    always_comb begin
        state_s  = state_r;
        song_s   = song_r;
        loop_s   = loop_r;
        step_s   = step_r;
        wrap_s   = wrap_r;
        tick_s   = tick_r;
        note_s   = note_r;
        addr_s   = addr_r;
        strobe_s = 1'b0;
        done_s   = 1'b0;
        if (stop && (state_r != ST_IDLE)) begin
            state_s = ST_IDLE;
            note_s  = REST_N;
            step_s  = STEP_ZERO;
            wrap_s  = 1'b0;
        end else if (start && !stop) begin
            // Start and restart-while-busy share the same path: no done pulse.
            state_s = ST_FETCH;
            song_s  = song_sel;
            loop_s  = loop_en;
            step_s  = STEP_ZERO;
            wrap_s  = 1'b0;
            addr_s  = {song_sel, STEP_ZERO};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_FETCH: begin
                    state_s = ST_LOAD;
                end
                ST_LOAD: begin
                    if ((rom_data == END_N) || wrap_r) begin
                        // An empty song (end at step 0) never loops, so loop mode cannot spin.
                        if (loop_r && (wrap_r || (step_r != STEP_ZERO))) begin
                            state_s = ST_FETCH;
                            step_s  = STEP_ZERO;
                            wrap_s  = 1'b0;
                            addr_s  = {song_r, STEP_ZERO};
                        end else begin
                            state_s = ST_IDLE;
                            note_s  = REST_N;
                            done_s  = 1'b1;
                            step_s  = STEP_ZERO;
                            wrap_s  = 1'b0;
                        end
                    end else begin
                        state_s  = ST_HOLD;
                        note_s   = rom_data;
                        strobe_s = 1'b1;
                        tick_s   = TICK_ONE;
                    end
                end
                ST_HOLD: begin
                    if (pause) begin
                        state_s = ST_HOLD;
                    end else if (tick_r == TICK_LAST) begin
                        state_s = ST_FETCH;
                        step_s  = step_r + STEP_ONE;
                        wrap_s  = (step_r == STEP_MAX);
                        addr_s  = {song_r, step_s};
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    note_s  = REST_N;
                    step_s  = STEP_ZERO;
                    wrap_s  = 1'b0;
                end
            endcase
        end
        busy_s    = (state_s != ST_IDLE);
        note_on_s = busy_s && (note_s != REST_N);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            song_r    <= {SONG_W{1'b0}};
            loop_r    <= 1'b0;
            step_r    <= STEP_ZERO;
            wrap_r    <= 1'b0;
            tick_r    <= {TICK_W{1'b0}};
            note_r    <= REST_N;
            note_on_r <= 1'b0;
            strobe_r  <= 1'b0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            addr_r    <= {(SONG_W+STEP_W){1'b0}};
        end else begin
            state_r   <= state_s;
            song_r    <= song_s;
            loop_r    <= loop_s;
            step_r    <= step_s;
            wrap_r    <= wrap_s;
            tick_r    <= tick_s;
            note_r    <= note_s;
            note_on_r <= note_on_s;
            strobe_r  <= strobe_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            addr_r    <= addr_s;
        end
    end

    assign rom_addr    = addr_r;
    assign note        = note_r;
    assign note_on     = note_on_r;
    assign note_strobe = strobe_r;
    assign step        = step_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios followed by random control
// traffic. Every cycle is compared against a countdown-based reference model.
module tb_melody_sequencer;

    localparam int CLK_DIV = 4;
    localparam int NOTE_W  = 5;
    localparam int STEP_W  = 2;
    localparam int SONG_W  = 2;
    localparam int REST    = 25;
    localparam int ENDC    = 31;
    localparam int NSTEPS  = 4;

    logic clk = 1'b0;
    logic rst_n, start, stop, pause, loop_en;
    logic [SONG_W-1:0] song_sel;
    logic [SONG_W+STEP_W-1:0] rom_addr;
    logic [NOTE_W-1:0] rom_data, note;
    logic note_on, note_strobe, busy, done;
    logic [STEP_W-1:0] step;

    logic [NOTE_W-1:0] mem [0:15];

    int n_chk = 0;
    int n_bad = 0;

    // Model state: where playback is and how many cycles remain until the next
    // ROM word is consumed (0 = consume this cycle).
    int m_active, m_song, m_loop, m_wrap, m_cd;
    int e_note, e_strobe, e_done, e_step, e_addr;

    melody_sequencer #(
        .CLK_DIV(CLK_DIV), .NOTE_W(NOTE_W), .STEP_W(STEP_W), .SONG_W(SONG_W),
        .REST_CODE(REST), .END_CODE(ENDC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .song_sel(song_sel), .loop_en(loop_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .note(note), .note_on(note_on),
        .note_strobe(note_strobe), .step(step), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous note ROM: data appears one cycle after the address.
    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        int code;
        e_strobe = 0;
        e_done   = 0;
        if (!rst_n) begin
            m_active = 0; m_wrap = 0; m_cd = 0;
            e_note = REST; e_step = 0; e_addr = 0;
        end else if (stop && m_active != 0) begin
            m_active = 0; m_wrap = 0; e_note = REST; e_step = 0;
        end else if (start && !stop) begin
            m_active = 1; m_song = song_sel; m_loop = loop_en;
            m_wrap = 0; e_step = 0; m_cd = 1; e_addr = m_song * NSTEPS;
        end else if (m_active != 0) begin
            if (m_cd == 0) begin
                code = (m_wrap != 0) ? ENDC : int'(mem[m_song * NSTEPS + e_step]);
                if (code == ENDC) begin
                    if (m_loop != 0 && (m_wrap != 0 || e_step != 0)) begin
                        e_step = 0; m_wrap = 0; m_cd = 1; e_addr = m_song * NSTEPS;
                    end else begin
                        m_active = 0; e_note = REST; e_done = 1; e_step = 0; m_wrap = 0;
                    end
                end else begin
                    e_note = code; e_strobe = 1; m_cd = CLK_DIV - 1;
                end
            end else if (!(m_cd >= 2 && pause)) begin
                // Leaving the final hold cycle advances to the next step.
                if (m_cd == 2) begin
                    m_wrap = (e_step == NSTEPS - 1) ? 1 : 0;
                    e_step = (e_step + 1) % NSTEPS;
                    e_addr = m_song * NSTEPS + e_step;
                end
                m_cd = m_cd - 1;
            end
        end
    endtask

    task automatic compare_all();
        chk("note",     note,        e_note);
        chk("note_on",  note_on,     (m_active != 0 && e_note != REST) ? 1 : 0);
        chk("strobe",   note_strobe, e_strobe);
        chk("done",     done,        e_done);
        chk("busy",     busy,        m_active);
        chk("step",     step,        e_step);
        chk("rom_addr", rom_addr,    e_addr);
    endtask

    task automatic cyc(input logic rs, input logic st, input logic sp, input logic pa,
                       input int sel, input logic lp);
        @(negedge clk);
        rst_n = rs; start = st; stop = sp; pause = pa;
        song_sel = sel[SONG_W-1:0]; loop_en = lp;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic load_song(input int s, input int a, input int b, input int c, input int d);
        mem[s*NSTEPS+0] = a[NOTE_W-1:0];
        mem[s*NSTEPS+1] = b[NOTE_W-1:0];
        mem[s*NSTEPS+2] = c[NOTE_W-1:0];
        mem[s*NSTEPS+3] = d[NOTE_W-1:0];
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        song_sel = '0; loop_en = 1'b0;
        load_song(0, 3, 7, 25, ENDC);
        load_song(1, 12, ENDC, 5, 6);
        load_song(2, ENDC, 1, 2, 3);
        load_song(3, 1, 2, 3, 4);

        // Reset state against literal reset values.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("rst_note", note, REST);
        chk("rst_busy", busy, 0);
        chk("rst_step", step, 0);
        chk("rst_addr", rom_addr, 0);

        // One-shot song 0.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(20);
        // Looping song 0, then stop.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        idle(30);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(3);
        // Pause for 5 cycles during the hold of the second note.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(6);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        idle(15);
        // Stop mid-song, then start and stop together from idle.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        idle(3);
        // Restart while busy onto song 1.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0);
        idle(12);
        // Empty song in loop mode must end.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b1);
        idle(8);
        // Song with no end marker: one-shot, then looping.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        idle(22);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1);
        idle(30);
        // Reset in the middle of a hold.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        idle(3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        chk("midrst_busy", busy, 0);
        chk("midrst_note", note, REST);
        idle(3);

        // Random control traffic with occasional ROM rewrites while idle.
        for (int n = 0; n < 4000; n++) begin
            if (m_active == 0 && $urandom_range(0, 9) == 0) begin
                for (int a = 0; a < 16; a++) begin
                    case ($urandom_range(0, 6))
                        0:       mem[a] = NOTE_W'(ENDC);
                        1:       mem[a] = NOTE_W'(REST);
                        default: mem[a] = NOTE_W'($urandom_range(0, 24));
                    endcase
                end
            end
            cyc(($urandom_range(0, 299) != 0),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 79) == 0),
                ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
